data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 86 ++++++++
 tb/tb_data_mem_responder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Wait-state data memory responder: captures one CPU request in IDLE, inserts
// WAIT_CYCLES wait states, then performs the access and pulses ready_o for one cycle.
module data_mem_responder #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  ready_o,
  output logic                  busy_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t                  state_q;
  logic [3:0]              cnt_q;
  logic                    ready_q;
  logic                    we_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_i) begin
            we_q    <= we_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            // With no wait states the access happens on the capture edge itself
            if (WAIT_CYCLES == 0) begin
              state_q <= S_RESP;
              ready_q <= 1'b1;
              if (we_i) mem_q[addr_i] <= wdata_i;
              else      rdata_q       <= mem_q[addr_i];
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= WAIT_INIT;
            end
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= S_RESP;
            ready_q <= 1'b1;
            if (we_q) mem_q[addr_q] <= wdata_q;
            else      rdata_q       <= mem_q[addr_q];
          end
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rdata_o = rdata_q;
  assign ready_o = ready_q;
  assign busy_o  = (state_q != S_IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: stimulus pushes expected responses, a negedge monitor pops and
// compares on every ready pulse for DUTs built with WAIT_CYCLES of 1, 0 and 15.
module tb_data_mem_responder;

  typedef struct {
    bit          rd;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  logic        m_req = 1'b0, m_we = 1'b0;
  logic [7:0]  m_addr = '0;
  logic [15:0] m_wdata = '0;
  logic [15:0] m_rdata;
  logic        m_ready, m_busy;
  logic [15:0] m_last = '0;

  logic        l_req = 1'b0, l_we = 1'b0;
  logic [7:0]  l_addr = '0;
  logic [15:0] l_wdata = '0;
  logic [15:0] a_rdata, b_rdata;
  logic        a_ready, a_busy, b_ready, b_busy;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_responder #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .WAIT_CYCLES(1)) u_main (
    .clock_i(clk), .reset_i(rst), .req_i(m_req), .we_i(m_we), .addr_i(m_addr),
    .wdata_i(m_wdata), .rdata_o(m_rdata), .ready_o(m_ready), .busy_o(m_busy));

  data_mem_responder #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .WAIT_CYCLES(0)) u_w0 (
    .clock_i(clk), .reset_i(rst), .req_i(l_req), .we_i(l_we), .addr_i(l_addr),
    .wdata_i(l_wdata), .rdata_o(a_rdata), .ready_o(a_ready), .busy_o(a_busy));

  data_mem_responder #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .WAIT_CYCLES(15)) u_w15 (
    .clock_i(clk), .reset_i(rst), .req_i(l_req), .we_i(l_we), .addr_i(l_addr),
    .wdata_i(l_wdata), .rdata_o(b_rdata), .ready_o(b_ready), .busy_o(b_busy));

  task automatic push(input int k, input bit rd, input logic [15:0] d, input int c);
    exp_t e;
    e.rd = rd; e.data = d; e.cyc = c;
    case (k)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic mon(input int k, input logic rdy, input logic [15:0] rd);
    exp_t e;
    bit   have;
    if (rdy !== 1'b1) return;
    have = 1'b0;
    case (k)
      0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
    endcase
    checks++;
    if (!have) begin
      errors++;
      $display("FAIL unexpected_ready dut%0d: ready at cycle %0d, required none", k, cyc);
      return;
    end
    if (cyc != e.cyc) begin
      errors++;
      $display("FAIL ready_cycle dut%0d: got cycle %0d, required %0d", k, cyc, e.cyc);
    end
    if (e.rd) begin
      checks++;
      if (rd !== e.data) begin
        errors++;
        $display("FAIL read_data dut%0d: got %h, required %h", k, rd, e.data);
      end
      if (k == 0) m_last = e.data;
    end
  endtask

  always @(negedge clk) begin
    mon(0, m_ready, m_rdata);
    mon(1, a_ready, a_rdata);
    mon(2, b_ready, b_rdata);
    checks++;
    if (m_rdata !== m_last) begin
      errors++;
      $display("FAIL rdata_hold: got %h at cycle %0d, required %h", m_rdata, cyc, m_last);
    end
  end

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  // Count busy cycles until the main DUT returns to idle, bounded.
  task automatic wait_main_idle(output int n);
    bit done = 1'b0;
    n = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (m_busy) n++;
      else done = 1'b1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL main_timeout: busy still %b, required 0", m_busy);
    end
  endtask

  task automatic m_txn(input bit we, input logic [7:0] a, input logic [15:0] d,
                       input logic [15:0] exp_rd, input bit scramble);
    int s, n;
    @(posedge clk); #1;
    m_req = 1'b1; m_we = we; m_addr = a; m_wdata = d;
    s = cyc + 1;
    push(0, !we, exp_rd, s + 1);
    @(posedge clk); #1;
    m_req = 1'b0;
    if (scramble) begin
      m_addr = 8'h20; m_wdata = 16'h1111; m_we = ~we;
    end
    wait_main_idle(n);
    check("busy_len", 16'(n), 16'd2);
  endtask

  task automatic m_b2b();
    int s, n;
    @(posedge clk); #1;
    s = cyc + 1;
    m_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      m_we    = (i % 2 == 0);
      m_addr  = 8'h10;
      m_wdata = (i < 2) ? 16'hA5A5 : 16'h5A5A;
      push(0, (i % 2 == 1), (i < 2) ? 16'hA5A5 : 16'h5A5A, s + 3 * i + 1);
      repeat ((i == 0) ? 1 : 3) @(posedge clk);
      #1;
    end
    m_req = 1'b0;
    wait_main_idle(n);
  endtask

  task automatic l_txn(input bit we, input logic [7:0] a, input logic [15:0] d,
                       input logic [15:0] exp_rd);
    int  s;
    bit  done = 1'b0;
    @(posedge clk); #1;
    l_req = 1'b1; l_we = we; l_addr = a; l_wdata = d;
    s = cyc + 1;
    push(1, !we, exp_rd, s);
    push(2, !we, exp_rd, s + 15);
    @(posedge clk); #1;
    l_req = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (!a_busy && !b_busy) done = 1'b1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL latency_timeout: busy %b/%b, required 0/0", a_busy, b_busy);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_rdata", m_rdata, 16'h0000);
    check("reset_ready", 16'(m_ready), 16'd0);
    check("reset_busy", 16'(m_busy), 16'd0);
    rst = 1'b0;

    // Fresh memory reads zero; a write must not disturb rdata until the next read.
    m_txn(1'b0, 8'hFF, 16'h0000, 16'h0000, 1'b0);
    m_txn(1'b1, 8'hFF, 16'h1234, 16'h0000, 1'b0);
    repeat (3) @(posedge clk);
    m_txn(1'b0, 8'hFF, 16'h0000, 16'h1234, 1'b0);

    m_txn(1'b1, 8'h05, 16'hBEEF, 16'h0000, 1'b0);
    m_txn(1'b0, 8'h05, 16'h0000, 16'hBEEF, 1'b0);

    // Inputs changed during WAIT must be ignored.
    m_txn(1'b1, 8'h40, 16'h7777, 16'h0000, 1'b1);
    m_txn(1'b0, 8'h40, 16'h0000, 16'h7777, 1'b0);
    m_txn(1'b0, 8'h20, 16'h0000, 16'h0000, 1'b0);

    m_b2b();

    // Latency of the zero-wait and fifteen-wait builds.
    l_txn(1'b1, 8'h01, 16'hCAFE, 16'h0000);
    l_txn(1'b0, 8'h01, 16'h0000, 16'hCAFE);

    // Reset during WAIT aborts the write and clears memory.
    @(posedge clk); #1;
    m_req = 1'b1; m_we = 1'b1; m_addr = 8'h30; m_wdata = 16'h5555;
    @(posedge clk); #1;
    m_req = 1'b0;
    check("pre_reset_busy", 16'(m_busy), 16'd1);
    rst = 1'b1;
    m_last = 16'h0000;
    #1;
    check("abort_busy", 16'(m_busy), 16'd0);
    check("abort_ready", 16'(m_ready), 16'd0);
    check("abort_rdata", m_rdata, 16'h0000);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    m_txn(1'b0, 8'h30, 16'h0000, 16'h0000, 1'b0);
    m_txn(1'b0, 8'h05, 16'h0000, 16'h0000, 1'b0);
    l_txn(1'b0, 8'h01, 16'h0000, 16'h0000);

    repeat (4) @(posedge clk);
    #1;
    check("pending_main", 16'(q0.size()), 16'd0);
    check("pending_w0", 16'(q1.size()), 16'd0);
    check("pending_w15", 16'(q2.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time %0t, required completion earlier", $time);
    $fatal(1);
  end

endmodule
